mac_result_collector: RTL

MAC_RESULT_COLLECTOR -- requirements
Module: mac_result_collector

---
 rtl/mac_result_collector.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mac_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_collector
// Description : Collects four result groups (4 rows x 18 bits each) from a MAC
//               unit into a 16-entry store, then unloads the 16 words over a
//               valid/ready port as 16-bit values with index 0..15.
//
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-low reset
//               web_in     - result-group strobe from the MAC unit
//               mu1_in..mu4_in - per-row 18-bit accumulators
//               clr        - synchronous abort/clear
//               out_ready  - downstream accepts out_data
//               out_valid  - out_data/out_idx valid
//               out_data   - 16-bit result word
//               out_idx    - result index 0..15
//               frame_done - one-cycle pulse after entry 15 is accepted
//               busy       - high whenever not collecting
//               overrun    - sticky: web_in seen while not collecting
//
// Config      : RESULT_SAT_EN defined   -> 18-to-16 unsigned saturation
//               RESULT_SAT_EN undefined -> drop the two LSBs
//
// Revision    : 1.0 - initial release
// ============================================================================
module mac_result_collector (
    input  logic        clk,
    input  logic        rst,
    input  logic        web_in,
    input  logic [17:0] mu1_in,
    input  logic [17:0] mu2_in,
    input  logic [17:0] mu3_in,
    input  logic [17:0] mu4_in,
    input  logic        clr,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [3:0]  out_idx,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun
);

    localparam logic [1:0] C_COLLECT = 2'd0;
    localparam logic [1:0] C_WRITE   = 2'd1;
    localparam logic [1:0] C_UNLOAD  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_grp;
    logic [1:0]       r_wcnt;
    logic [3:0]       r_rp;
    logic             r_frame_done;
    logic             r_overrun;
    logic [3:0][17:0] r_mu_d;   // element 0 holds row 1
    logic [3:0][17:0] r_h;
    logic [17:0]      r_mem [0:15];

    logic [17:0]      w_rd;
    logic [15:0]      w_conv;

    // ------------------------------------------------------------------------
    // Control path. The MAC clears its accumulators on the edge that raises
    // web_in, so the group is taken from the one-cycle-delayed copy.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= C_COLLECT;
            r_grp        <= 2'd0;
            r_wcnt       <= 2'd0;
            r_rp         <= 4'd0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_mu_d       <= '0;
            r_h          <= '0;
        end else begin
            r_mu_d       <= {mu4_in, mu3_in, mu2_in, mu1_in};
            r_frame_done <= 1'b0;
            if (clr) begin
                r_state   <= C_COLLECT;
                r_grp     <= 2'd0;
                r_wcnt    <= 2'd0;
                r_rp      <= 4'd0;
                r_overrun <= 1'b0;
            end else begin
                if (web_in && (r_state != C_COLLECT)) begin
                    r_overrun <= 1'b1;
                end
                case (r_state)
                    C_COLLECT: begin
                        if (web_in) begin
                            r_h     <= r_mu_d;
                            r_wcnt  <= 2'd0;
                            r_state <= C_WRITE;
                        end
                    end
                    C_WRITE: begin
                        r_wcnt <= r_wcnt + 2'd1;
                        if (r_wcnt == 2'd3) begin
                            r_grp   <= r_grp + 2'd1;
                            r_state <= (r_grp == 2'd3) ? C_UNLOAD : C_COLLECT;
                        end
                    end
                    C_UNLOAD: begin
                        if (out_ready) begin
                            r_rp <= r_rp + 4'd1;
                            if (r_rp == 4'd15) begin
                                r_state      <= C_COLLECT;
                                r_frame_done <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= C_COLLECT;
                endcase
            end
        end
    end

    // Result store: no reset, contents are always rewritten before unloading.
    always_ff @(posedge clk) begin
        if ((r_state == C_WRITE) && !clr) begin
            r_mem[{r_grp, r_wcnt}] <= r_h[r_wcnt];
        end
    end

    assign w_rd = r_mem[r_rp];

`ifdef RESULT_SAT_EN
    assign w_conv = (|w_rd[17:16]) ? 16'hFFFF : w_rd[15:0];
`else
    assign w_conv = w_rd[17:2];
`endif

    assign out_valid  = (r_state == C_UNLOAD);
    // Forced to zero outside UNLOAD so the idle/reset value is defined.
    assign out_data   = out_valid ? w_conv : 16'd0;
    assign out_idx    = r_rp;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != C_COLLECT);
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
